// File: rtl/exposure_ctrl_fsm_pkg.sv
// -----------------------------------------------------------------------------
// exposure_ctrl_fsm_pkg
// Shared types and constants for the camera exposure/readout controller:
// controller state encoding, exposure register limits, timer standby value,
// watchdog margin and readout sequence length.
// -----------------------------------------------------------------------------
package exposure_ctrl_fsm_pkg;

    // Exposure register width and limits (in clock cycles).
    localparam int EXP_W       = 5;
    localparam int EXP_MIN     = 2;
    localparam int EXP_MAX     = 30;
    localparam int EXP_DEFAULT = 16;

    // EX_time value the exposure timer treats as "standby"; a real exposure
    // must never request it.
    localparam int TIMER_STANDBY = 31;

    // Extra cycles beyond EX_time before the Ovf5 watchdog gives up.
    localparam int TMO_MARGIN = 4;
    localparam int WD_W       = $clog2(EXP_MAX + TMO_MARGIN + 1);

    // Two rows of four steps each: active, active+ADC, active, gap.
    localparam int READ_STEPS = 8;
    localparam int STEP_W     = $clog2(READ_STEPS);

    typedef enum logic [1:0] {
        IDLE,
        EXPOSE,
        READ
    } state_t;

endpackage : exposure_ctrl_fsm_pkg

// File: rtl/exposure_reg.sv
// -----------------------------------------------------------------------------
// exposure_reg
// Saturating up/down register holding the exposure time. Moves by one step
// per enabled cycle; simultaneous up and down requests cancel out.
//
// Ports:
//   Clk    in   clock, rising edge
//   Reset  in   asynchronous, active-high; loads RESET_VAL
//   en     in   allow the value to change this cycle
//   inc    in   request +1 (saturates at MAX_VAL)
//   dec    in   request -1 (saturates at MIN_VAL)
//   value  out  current register value
// -----------------------------------------------------------------------------
module exposure_reg
    import exposure_ctrl_fsm_pkg::*;
#(
    parameter int WIDTH     = EXP_W,
    parameter int MIN_VAL   = EXP_MIN,
    parameter int MAX_VAL   = EXP_MAX,
    parameter int RESET_VAL = EXP_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] value
);

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values of all others regardless of
    // statement or process ordering.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            value <= WIDTH'(RESET_VAL);
        end else if (en) begin
            if (inc && !dec && (value < WIDTH'(MAX_VAL))) begin
                value <= value + 1'b1;
            end else if (dec && !inc && (value > WIDTH'(MIN_VAL))) begin
                value <= value - 1'b1;
            end
        end
    end

endmodule : exposure_reg

// File: rtl/exposure_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// exposure_ctrl_fsm
// Camera exposure/readout controller. While idle the exposure time can be
// trimmed with the buttons; Init starts the exposure timer, holds Expose until
// the timer's Ovf5 pulse (or a watchdog expiry), then runs a fixed two-row
// readout sequence. All outputs are registered (Moore).
//
// Ports:
//   Clk           in   clock, rising edge
//   Reset         in   asynchronous, active-high
//   Init          in   start an exposure (honoured in IDLE only)
//   Exp_increase  in   +1 exposure per cycle while idle
//   Exp_decrease  in   -1 exposure per cycle while idle
//   Ovf5          in   timer done pulse (honoured in EXPOSE only)
//   Start         out  one-cycle timer start pulse
//   EX_time       out  exposure end count to the timer
//   Expose        out  pixel exposure enable
//   Erase         out  pixel erase, high while idle
//   NRE_1         out  row 1 readout enable, active-low
//   NRE_2         out  row 2 readout enable, active-low
//   ADC           out  ADC sample strobe
//   Timeout       out  sticky: last exposure ended by the watchdog
// -----------------------------------------------------------------------------
module exposure_ctrl_fsm
    import exposure_ctrl_fsm_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Init,
    input  logic             Exp_increase,
    input  logic             Exp_decrease,
    input  logic             Ovf5,
    output logic             Start,
    output logic [EXP_W-1:0] EX_time,
    output logic             Expose,
    output logic             Erase,
    output logic             NRE_1,
    output logic             NRE_2,
    output logic             ADC,
    output logic             Timeout
);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              timeout_d;
    logic              start_d, expose_d, erase_d, nre1_d, nre2_d, adc_d;
    logic              exp_en;

    // Buttons only act while idle, and Init takes priority over them.
    assign exp_en = (state_q == IDLE) && !Init;

    // Upper limit is kept clear of the timer's standby code.
    exposure_reg #(
        .WIDTH     (EXP_W),
        .MIN_VAL   (EXP_MIN),
        .MAX_VAL   ((EXP_MAX < TIMER_STANDBY) ? EXP_MAX : TIMER_STANDBY - 1),
        .RESET_VAL (EXP_DEFAULT)
    ) u_exposure_reg (
        .Clk   (Clk),
        .Reset (Reset),
        .en    (exp_en),
        .inc   (Exp_increase),
        .dec   (Exp_decrease),
        .value (EX_time)
    );

    // State, counters and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            wd_q    <= '0;
            Timeout <= 1'b0;
            Start   <= 1'b0;
            Expose  <= 1'b0;
            Erase   <= 1'b1;
            NRE_1   <= 1'b1;
            NRE_2   <= 1'b1;
            ADC     <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            wd_q    <= wd_d;
            Timeout <= timeout_d;
            Start   <= start_d;
            Expose  <= expose_d;
            Erase   <= erase_d;
            NRE_1   <= nre1_d;
            NRE_2   <= nre2_d;
            ADC     <= adc_d;
        end
    end

    // Next-state, watchdog and step counter.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        step_d    = step_q;
        wd_d      = wd_q;
        timeout_d = Timeout;

        unique case (state_q)
            IDLE: begin
                if (Init) begin
                    state_d   = EXPOSE;
                    step_d    = '0;
                    timeout_d = 1'b0;
                    wd_d      = WD_W'(EX_time) + WD_W'(TMO_MARGIN);
                end
            end

            EXPOSE: begin
                wd_d = (wd_q != '0) ? wd_q - 1'b1 : '0;
                // Ovf5 is checked first so a coincident watchdog expiry is
                // not reported as a timeout.
                if (Ovf5) begin
                    state_d = READ;
                    step_d  = '0;
                end else if (wd_q <= WD_W'(1)) begin
                    state_d   = READ;
                    step_d    = '0;
                    timeout_d = 1'b1;
                end
            end

            READ: begin
                if (step_q == STEP_W'(READ_STEPS - 1)) begin
                    state_d = IDLE;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up
    // with the state they describe.
    always_comb begin
        start_d  = (state_q == IDLE) && (state_d == EXPOSE);
        expose_d = (state_d == EXPOSE);
        erase_d  = (state_d == IDLE);
        nre1_d   = 1'b1;
        nre2_d   = 1'b1;
        adc_d    = 1'b0;
        // Step bit 2 selects the row, bits 1:0 the phase; phase 3 is the gap.
        if ((state_d == READ) && (step_d[1:0] != 2'd3)) begin
            if (step_d[2]) begin
                nre2_d = 1'b0;
            end else begin
                nre1_d = 1'b0;
            end
            adc_d = (step_d[1:0] == 2'd1);
        end
    end

endmodule : exposure_ctrl_fsm

// File: tb/tb_exposure_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_exposure_ctrl_fsm
// Directed bench for exposure_ctrl_fsm. Each stimulus step pushes the output
// vector expected after the next clock edge; the vector is popped and compared
// on the following falling edge.
// Vector layout: {Start, Expose, Erase, NRE_1, NRE_2, ADC, Timeout, EX_time}.
// -----------------------------------------------------------------------------
module tb_exposure_ctrl_fsm;

    localparam int MIN_V   = 2;
    localparam int MAX_V   = 30;
    localparam int DEF_V   = 16;
    localparam int MARGIN  = 4;

    // {NRE_1, NRE_2, ADC} for readout steps 0..7.
    localparam logic [2:0] READ_PAT [8] = '{3'b010, 3'b011, 3'b010, 3'b110,
                                            3'b100, 3'b101, 3'b100, 3'b110};

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Init;
    logic       Exp_increase;
    logic       Exp_decrease;
    logic       Ovf5;
    logic       Start;
    logic [4:0] EX_time;
    logic       Expose;
    logic       Erase;
    logic       NRE_1;
    logic       NRE_2;
    logic       ADC;
    logic       Timeout;

    exposure_ctrl_fsm dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Init         (Init),
        .Exp_increase (Exp_increase),
        .Exp_decrease (Exp_decrease),
        .Ovf5         (Ovf5),
        .Start        (Start),
        .EX_time      (EX_time),
        .Expose       (Expose),
        .Erase        (Erase),
        .NRE_1        (NRE_1),
        .NRE_2        (NRE_2),
        .ADC          (ADC),
        .Timeout      (Timeout)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        logic [11:0] v;
    } sb_t;

    sb_t  sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   ex_m;
    logic tmo_m;

    function automatic logic [11:0] mk(input logic s, input logic x, input logic e,
                                       input logic n1, input logic n2, input logic a,
                                       input logic t, input int ex);
        return {s, x, e, n1, n2, a, t, 5'(ex)};
    endfunction

    function automatic logic [11:0] idle_vec();
        return mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, tmo_m, ex_m);
    endfunction

    function automatic logic [11:0] read_vec(input int s);
        logic [2:0] p;
        p = READ_PAT[s];
        return mk(1'b0, 1'b0, 1'b0, p[2], p[1], p[0], tmo_m, ex_m);
    endfunction

    task automatic push(input string tag, input logic [11:0] v);
        sb_t e;
        e.tag = tag;
        e.v   = v;
        sb_q.push_back(e);
    endtask

    task automatic check_now();
        sb_t         e;
        logic [11:0] obs;
        obs = {Start, Expose, Erase, NRE_1, NRE_2, ADC, Timeout, EX_time};
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: observed %h, no expected entry", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.v) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic drive(input logic init, input logic inc, input logic dec, input logic ovf);
        Init         = init;
        Exp_increase = inc;
        Exp_decrease = dec;
        Ovf5         = ovf;
    endtask

    task automatic cyc();
        @(posedge Clk);
        @(negedge Clk);
        check_now();
    endtask

    task automatic buttons(input logic inc, input logic dec, input int n, input string name);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, inc, dec, 1'b0);
            if (inc && !dec)      ex_m = (ex_m < MAX_V) ? ex_m + 1 : MAX_V;
            else if (dec && !inc) ex_m = (ex_m > MIN_V) ? ex_m - 1 : MIN_V;
            push($sformatf("%s[%0d]", name, i), idle_vec());
            cyc();
        end
    endtask

    // One exposure run. ovf_call: step index at which Ovf5 is driven (0 = never).
    // noisy: drive Init/Exp_increase (and stray Ovf5 in READ) throughout.
    // last_step: stop after this readout step has been checked (7 = full run).
    task automatic exposure(input int ovf_call, input bit noisy, input int last_step,
                            input string name);
        int limit;
        int end_call;
        bit by_wd;
        limit    = ex_m + MARGIN;
        by_wd    = !((ovf_call > 0) && (ovf_call <= limit));
        end_call = by_wd ? limit : ovf_call;

        drive(1'b1, noisy, 1'b0, 1'b0);
        tmo_m = 1'b0;
        push({name, "_start"}, mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ex_m));
        cyc();

        for (int j = 1; j < end_call; j++) begin
            drive(noisy, noisy, 1'b0, 1'b0);
            push($sformatf("%s_expose[%0d]", name, j),
                 mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ex_m));
            cyc();
        end

        drive(noisy, noisy, 1'b0, !by_wd);
        if (by_wd) tmo_m = 1'b1;
        push({name, "_read[0]"}, read_vec(0));
        cyc();

        for (int s = 1; s <= last_step; s++) begin
            drive(noisy, noisy, 1'b0, noisy);
            push($sformatf("%s_read[%0d]", name, s), read_vec(s));
            cyc();
        end

        if (last_step == 7) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            push({name, "_idle"}, idle_vec());
            cyc();
        end
    endtask

    initial begin
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        ex_m  = DEF_V;
        tmo_m = 1'b0;

        // Reset state.
        #3;
        push("reset", idle_vec());
        check_now();
        @(negedge Clk);
        Reset = 1'b0;

        // Exposure register saturation and cancelling buttons.
        buttons(1'b1, 1'b0, 20, "inc_sat");
        buttons(1'b0, 1'b1, 40, "dec_sat");
        buttons(1'b1, 1'b1, 3, "both");
        buttons(1'b1, 1'b0, 14, "to16");

        // Normal exposure, Ovf5 returned 16 cycles after Start.
        exposure(17, 1'b0, 7, "ovf16");

        // Watchdog expiry with EX_time = 5.
        buttons(1'b0, 1'b1, 11, "to5");
        exposure(0, 1'b0, 7, "wdog");

        // Stray Ovf5 while idle; Timeout stays set.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            push($sformatf("stray_ovf_idle[%0d]", i), idle_vec());
            cyc();
        end

        // Buttons, Init and stray Ovf5 during EXPOSE/READ; Timeout cleared.
        exposure(6, 1'b1, 7, "noisy");

        // Ovf5 on the same edge as watchdog expiry.
        exposure(5 + MARGIN, 1'b0, 7, "coincide");

        // Reset in the middle of the readout.
        buttons(1'b1, 1'b0, 11, "to16b");
        exposure(17, 1'b0, 5, "rst_run");
        #2;
        Reset = 1'b1;
        ex_m  = DEF_V;
        tmo_m = 1'b0;
        #1;
        push("rst_async", idle_vec());
        check_now();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        push("rst_held", idle_vec());
        cyc();
        Reset = 1'b0;

        // Clean run after reset.
        exposure(3, 1'b0, 7, "after_rst");

        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover: observed %0d entries, required 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_exposure_ctrl_fsm
